alu_multibyte_seq: RTL

//  Sequences the 8-bit combinational ALU/shifter to run NBYTES-wide arithmetic/logic ops, one byte per cycle, LSB first.

---
 rtl/pico_alu_pkg.sv | 36 +++
 rtl/alu_multibyte_seq.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pico_alu_pkg.sv
// rtl/pico_alu_pkg.sv - shared ALU opcodes, sequencer state encoding and byte width
package pico_alu_pkg;

    localparam int D_WIDTH      = 8;
    localparam int OPCODE_WIDTH = 4;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_ADDC = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_SUBC = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_NAND = 4'b0111;
    localparam logic [3:0] ALU_SHL  = 4'b1000;
    localparam logic [3:0] ALU_SHR  = 4'b1001;
    localparam logic [3:0] ALU_ROTL = 4'b1010;
    localparam logic [3:0] ALU_ROTR = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

    // Arithmetic codes carry/borrow between byte passes; logic codes do not.
    function automatic logic is_arith(input logic [3:0] fn);
        return (fn[3:2] == 2'b00);
    endfunction

    // Codes whose first byte takes the requester's carry/borrow in.
    function automatic logic uses_cin(input logic [3:0] fn);
        return (fn == ALU_ADDC) || (fn == ALU_SUBC);
    endfunction

endpackage

// File: rtl/alu_multibyte_seq.sv
// rtl/alu_multibyte_seq.sv - runs wide ops through the shared 8-bit ALU one byte per cycle
module alu_multibyte_seq #(
    parameter int NBYTES       = 2,
    parameter int D_WIDTH      = 8,
    parameter int OPCODE_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [OPCODE_WIDTH-1:0]   req_fn,
    input  logic [8*NBYTES-1:0]       req_a,
    input  logic [8*NBYTES-1:0]       req_b,
    input  logic                      req_carry_in,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [8*NBYTES-1:0]       rsp_result,
    output logic                      rsp_carry,
    output logic                      rsp_zero,
    output logic                      rsp_err,
    output logic                      busy,
    output logic                      alu_enable,
    output logic [OPCODE_WIDTH-1:0]   alu_fn,
    output logic [D_WIDTH-1:0]        alu_a,
    output logic [D_WIDTH-1:0]        alu_b,
    output logic                      alu_carry_in,
    input  logic [D_WIDTH-1:0]        alu_result,
    input  logic                      alu_carry_out,
    input  logic                      alu_zero_out
);
    import pico_alu_pkg::*;

    localparam int W  = 8 * NBYTES;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

    seq_state_e              state_q, state_d;
    logic [CW-1:0]           cnt_q;
    logic [OPCODE_WIDTH-1:0] fn_q;
    logic [W-1:0]            a_q, b_q, res_q;
    logic                    chain_q, zero_q, err_q;
    logic [OPCODE_WIDTH-1:0] byte_fn;
    logic [W-1:0]            res_ins;
    logic                    byte_zero;
    logic                    accept;
    logic                    unused_alu_zero;

    // Zero flag is rebuilt from the byte results, so the ALU's own flag is not needed.
    assign unused_alu_zero = alu_zero_out;

    assign accept    = req_valid & req_ready;
    assign busy      = (state_q != ST_IDLE);
    assign byte_zero = (alu_result == '0);

    // New byte lands at the MSB end; after NBYTES passes byte 0 sits at the LSB.
    assign res_ins = (res_q >> D_WIDTH) | (W'(alu_result) << (W - D_WIDTH));

    // Upper bytes of plain ADD/SUB must consume the chained carry/borrow.
    always_comb begin
        byte_fn = fn_q;
        if (cnt_q != '0) begin
            if (fn_q == ALU_ADD) byte_fn = ALU_ADDC;
            if (fn_q == ALU_SUB) byte_fn = ALU_SUBC;
        end
    end

    assign rsp_result = res_q;
    assign rsp_carry  = chain_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state plus handshake and ALU drive; ALU inputs are held at 0 outside EXEC.
    always_comb begin
        state_d      = state_q;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        alu_enable   = 1'b0;
        alu_fn       = '0;
        alu_a        = '0;
        alu_b        = '0;
        alu_carry_in = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = req_fn[OPCODE_WIDTH-1] ? ST_RESP : ST_EXEC;
            end
            ST_EXEC: begin
                alu_enable   = 1'b1;
                alu_fn       = byte_fn;
                alu_a        = a_q[D_WIDTH-1:0];
                alu_b        = b_q[D_WIDTH-1:0];
                alu_carry_in = is_arith(fn_q) ? chain_q : 1'b0;
                if (cnt_q == LAST_BYTE) state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, per-byte result/flag accumulation and byte counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            fn_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            chain_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        fn_q    <= req_fn;
                        a_q     <= req_a;
                        b_q     <= req_b;
                        cnt_q   <= '0;
                        res_q   <= '0;
                        err_q   <= req_fn[OPCODE_WIDTH-1];
                        zero_q  <= ~req_fn[OPCODE_WIDTH-1];
                        chain_q <= uses_cin(req_fn) ? req_carry_in : 1'b0;
                    end
                end
                ST_EXEC: begin
                    a_q     <= a_q >> D_WIDTH;
                    b_q     <= b_q >> D_WIDTH;
                    res_q   <= res_ins;
                    chain_q <= is_arith(fn_q) ? alu_carry_out : 1'b0;
                    zero_q  <= zero_q & byte_zero;
                    cnt_q   <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
